softmax_norm_seq: RTL and testbench

//  Softmax normalisation sequencer. It sits between reduce_sum and the write-back path.
//  It takes one Q8.8 exponent sum per vector and drives the addr port of recip_lut with
//  sum[15:8], capturing the Q0.16 reciprocal it returns. It then streams len Q8.8 exp values

---
 rtl/softmax_norm_seq_pkg.sv | 21 ++
 rtl/softmax_norm_seq_mul_round.sv | 32 +++
 rtl/softmax_norm_seq.sv | 135 +++++++++++++
 tb/tb_softmax_norm_seq.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/softmax_norm_seq_pkg.sv
// Shared fixed-point widths and sequencer state encoding for the softmax
// normalisation path.
package softmax_norm_seq_pkg;

    localparam int Q88_W      = 16;
    localparam int Q016_W     = 16;
    localparam int Q08_W      = 8;
    localparam int LUT_ADDR_W = 8;
    localparam int PROD_W     = Q88_W + Q016_W;
    localparam int FRAC_SHIFT = 16;

    localparam logic [Q08_W-1:0] PROB_MAX = 8'd255;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        LATCH  = 2'd2,
        STREAM = 2'd3
    } norm_state_e;

endpackage

// File: rtl/softmax_norm_seq_mul_round.sv
// Combinational Q8.8 x Q0.16 multiply, round-half-up to Q0.8 and clamp to
// the largest representable probability.
module softmax_norm_seq_mul_round
    import softmax_norm_seq_pkg::*;
(
    input  logic [Q88_W-1:0]  exp_val,
    input  logic [Q016_W-1:0] recip,
    output logic [Q08_W-1:0]  prob
);

    localparam int RND_W = PROD_W - FRAC_SHIFT + 1;

    // One guard bit above the product so the rounding bias can never wrap.
    function automatic logic [RND_W-1:0] round_q16(input logic [PROD_W-1:0] p);
        logic [PROD_W:0] biased;
        biased = {1'b0, p} + ((PROD_W + 1)'(1) << (FRAC_SHIFT - 1));
        return biased[PROD_W:FRAC_SHIFT];
    endfunction

    function automatic logic [Q08_W-1:0] sat_q08(input logic [RND_W-1:0] v);
        if (v > RND_W'(PROB_MAX)) begin
            return PROB_MAX;
        end
        return v[Q08_W-1:0];
    endfunction

    logic [PROD_W-1:0] prod;

    assign prod = exp_val * recip;
    assign prob = sat_q08(round_q16(prod));

endmodule

// File: rtl/softmax_norm_seq.sv
// Softmax normalisation sequencer: looks up 1/sum once per vector, then scales
// each streamed exp value into a Q0.8 probability under valid/ready.
module softmax_norm_seq
    import softmax_norm_seq_pkg::*;
#(
    parameter int MAX_LEN = 64,
    parameter int LEN_W   = $clog2(MAX_LEN)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [Q88_W-1:0]      sum_in,
    input  logic [LEN_W:0]        len,
    output logic                  busy,
    output logic                  done,
    output logic [LUT_ADDR_W-1:0] recip_addr,
    input  logic [Q016_W-1:0]     recip_data,
    input  logic                  exp_valid,
    input  logic [Q88_W-1:0]      exp_data,
    output logic                  exp_ready,
    output logic                  out_valid,
    output logic [Q08_W-1:0]      out_data,
    output logic                  out_last,
    input  logic                  out_ready
);

    norm_state_e          state;
    norm_state_e          state_nxt;
    logic [LEN_W:0]       len_q;
    logic [LEN_W:0]       in_cnt;
    logic [Q016_W-1:0]    recip_q;
    logic [Q08_W-1:0]     prob;
    logic                 accept;
    logic                 emit;
    logic                 sum_frac_unused;

    // Only the integer byte of the sum indexes the reciprocal table.
    assign sum_frac_unused = ^sum_in[Q88_W-LUT_ADDR_W-1:0];

    assign accept = exp_valid && exp_ready;
    assign emit   = out_valid && out_ready;

    softmax_norm_seq_mul_round u_mul_round (
        .exp_val (exp_data),
        .recip   (recip_q),
        .prob    (prob)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        exp_ready = 1'b0;
        case (state)
            IDLE: begin
                if (start && (len != '0)) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                state_nxt = LATCH;
            end
            LATCH: begin
                state_nxt = STREAM;
            end
            STREAM: begin
                exp_ready = (in_cnt < len_q) && (!out_valid || out_ready);
                if (out_valid && out_ready && out_last) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q      <= '0;
            in_cnt     <= '0;
            recip_addr <= '0;
            recip_q    <= '0;
            done       <= 1'b0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_data   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len == '0) begin
                            done <= 1'b1;
                        end else begin
                            len_q      <= len;
                            in_cnt     <= '0;
                            recip_addr <= sum_in[Q88_W-1:Q88_W-LUT_ADDR_W];
                        end
                    end
                end
                // LUT has registered the address during FETCH; its data is valid now.
                LATCH: begin
                    recip_q <= recip_data;
                end
                // Output register refills on the same edge it drains, so a full
                // stream sustains one element per cycle.
                STREAM: begin
                    if (accept) begin
                        out_data  <= prob;
                        out_valid <= 1'b1;
                        out_last  <= (in_cnt == (len_q - 1'b1));
                        in_cnt    <= in_cnt + 1'b1;
                    end else if (emit) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end
                    if (emit && out_last) begin
                        done <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_softmax_norm_seq.sv
// Randomised bench for softmax_norm_seq with a behavioural reciprocal LUT and
// an arithmetic reference model of the expected probabilities.
module tb_softmax_norm_seq;

    localparam int MAX_LEN = 64;
    localparam int LEN_W   = $clog2(MAX_LEN);

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [15:0]      sum_in = 16'd0;
    logic [LEN_W:0]   len = '0;
    logic             busy;
    logic             done;
    logic [7:0]       recip_addr;
    logic [15:0]      recip_data;
    logic             exp_valid = 1'b0;
    logic [15:0]      exp_data = 16'd0;
    logic             exp_ready;
    logic             out_valid;
    logic [7:0]       out_data;
    logic             out_last;
    logic             out_ready = 1'b0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    softmax_norm_seq #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .sum_in     (sum_in),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .recip_addr (recip_addr),
        .recip_data (recip_data),
        .exp_valid  (exp_valid),
        .exp_data   (exp_data),
        .exp_ready  (exp_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_ready  (out_ready)
    );

    // Reciprocal table: round-down 2^16/addr, addresses 0 and 1 clamp to 0xFFFF.
    function automatic logic [15:0] lut_val(input logic [7:0] a);
        if (a <= 8'd1) return 16'hFFFF;
        return 16'(32'd65536 / {24'd0, a});
    endfunction

    logic [7:0] lut_addr_q = 8'd0;
    always @(posedge clk) lut_addr_q <= recip_addr;
    assign recip_data = lut_val(lut_addr_q);

    function automatic logic [7:0] ref_prob(input logic [15:0] e, input logic [15:0] s);
        longint p;
        p = (longint'(e) * longint'(lut_val(s[15:8])) + 64'sd32768) / 64'sd65536;
        return (p > 64'sd255) ? 8'd255 : 8'(p);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        if (obs !== req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, req);
        end
    endtask

    task automatic run_vec(input logic [15:0] s, input int n, input int mode,
                           input bit use_fix, input logic [15:0] fix,
                           input int abort_at, input bit now);
        logic [15:0] ed   [MAX_LEN];
        logic [7:0]  expq [MAX_LEN];
        logic [3:0]  pat;
        logic [7:0]  prev_data;
        bit          prev_stall;
        bit          finished;
        bit          aborted;
        int          cyc;
        int          in_i;
        int          out_i;
        int          budget;
        pat = 4'b1001;
        for (int i = 0; i < n; i++) begin
            if (use_fix) ed[i] = fix;
            else begin
                case ($urandom_range(0, 2))
                    0: ed[i] = 16'($urandom);
                    1: ed[i] = 16'($urandom_range(0, 32'(s)));
                    default: ed[i] = 16'($urandom_range(0, 255));
                endcase
            end
            expq[i] = ref_prob(ed[i], s);
        end
        if (!now) begin
            @(negedge clk);
            #1;
            chk("idle_busy", 32'(busy), 32'd0);
        end
        start     = 1'b1;
        sum_in    = s;
        len       = (LEN_W + 1)'(n);
        exp_valid = 1'b1;
        exp_data  = ed[0];
        out_ready = 1'b1;
        cyc = 0; in_i = 0; out_i = 0;
        prev_stall = 1'b0; prev_data = 8'd0;
        finished = 1'b0; aborted = 1'b0;
        budget = 20 * n + 50;
        while (!finished && !aborted && cyc < budget) begin
            @(negedge clk);
            cyc++;
            start     = ($urandom_range(0, 3) == 0);
            sum_in    = 16'($urandom);
            len       = (LEN_W + 1)'($urandom_range(0, MAX_LEN));
            exp_valid = (in_i < n) ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
            exp_data  = (in_i < n) ? ed[in_i] : 16'($urandom);
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = pat[cyc % 4];
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            chk("busy", 32'(busy), 32'd1);
            chk("recip_addr", 32'(recip_addr), 32'(s[15:8]));
            chk("done_idle", 32'(done), 32'd0);
            if (cyc <= 2) chk("ready_latency", 32'(exp_ready), 32'd0);
            if (cyc == 3) chk("ready_first", 32'(exp_ready), 32'd1);
            if (in_i >= n) chk("ready_exhausted", 32'(exp_ready), 32'd0);
            if (prev_stall) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", 32'(out_data), 32'(prev_data));
            end
            if (out_valid && !out_ready) chk("stall_ready", 32'(exp_ready), 32'd0);
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (exp_valid && exp_ready) in_i++;
            if (out_valid && out_ready) begin
                chk("data", 32'(out_data), 32'(expq[out_i]));
                chk("last", 32'(out_last), 32'(out_i == n - 1));
                out_i++;
                if (out_i == n) finished = 1'b1;
                if (abort_at != 0 && out_i == abort_at) begin
                    #2;
                    rst = 1'b1;
                    #1;
                    chk("rst_out_valid", 32'(out_valid), 32'd0);
                    chk("rst_out_data", 32'(out_data), 32'd0);
                    chk("rst_out_last", 32'(out_last), 32'd0);
                    chk("rst_busy", 32'(busy), 32'd0);
                    chk("rst_exp_ready", 32'(exp_ready), 32'd0);
                    chk("rst_done", 32'(done), 32'd0);
                    chk("rst_recip_addr", 32'(recip_addr), 32'd0);
                    @(negedge clk);
                    rst = 1'b0; start = 1'b0; exp_valid = 1'b0;
                    aborted = 1'b1;
                end
            end
        end
        if (!aborted) begin
            chk("out_count", 32'(out_i), 32'(n));
            @(negedge clk);
            start = 1'b0; exp_valid = 1'b0; out_ready = 1'b1;
            #1;
            chk("done_pulse", 32'(done), 32'd1);
            chk("done_busy", 32'(busy), 32'd0);
            chk("done_no_extra", 32'(out_valid), 32'd0);
        end
    endtask

    task automatic run_empty(input logic [15:0] s);
        logic [7:0] prev_addr;
        @(negedge clk);
        prev_addr = recip_addr;
        start  = 1'b1;
        sum_in = s;
        len    = '0;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("empty_done", 32'(done), 32'd1);
        chk("empty_busy", 32'(busy), 32'd0);
        chk("empty_addr", 32'(recip_addr), 32'(prev_addr));
        @(negedge clk);
        #1;
        chk("empty_done_clear", 32'(done), 32'd0);
        chk("empty_busy2", 32'(busy), 32'd0);
    endtask

    initial begin
        #1 rst = 1'b1;
        #2;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_exp_ready", 32'(exp_ready), 32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_last", 32'(out_last), 32'd0);
        chk("reset_out_data", 32'(out_data), 32'd0);
        chk("reset_recip_addr", 32'(recip_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_vec(16'h0400, 1, 0, 1'b1, 16'h0100, 0, 1'b0);
        run_vec(16'h0400, 1, 0, 1'b1, 16'h0400, 0, 1'b0);
        run_vec(16'h0080, 1, 0, 1'b1, 16'h0001, 0, 1'b0);
        run_vec(16'h0A37, 4, 1, 1'b0, 16'h0000, 0, 1'b0);
        run_empty(16'h1234);
        run_vec(16'h0800, 8, 0, 1'b0, 16'h0000, 2, 1'b0);
        run_vec(16'h0800, 8, 0, 1'b0, 16'h0000, 0, 1'b0);
        run_vec(16'h1F00, 5, 2, 1'b0, 16'h0000, 0, 1'b1);

        for (int k = 0; k < 10; k++) begin
            logic [15:0] s;
            s = (k % 3 == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            run_vec(s, $urandom_range(1, MAX_LEN), $urandom_range(0, 2), 1'b0, 16'h0000,
                    0, 1'($urandom_range(0, 1)));
        end
        run_empty(16'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "time limit");
    end

endmodule
